// File: rtl/tictactoe_pkg.sv
// Shared types, board geometry and cursor arithmetic for the tic-tac-toe sequencer.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int NUM_LINES = 8;

  // Bit k-1 of each mask is cell k: rows, columns, then the two diagonals.
  localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
    9'b001_010_100,
    9'b100_010_001,
    9'b100_100_100,
    9'b010_010_010,
    9'b001_001_001,
    9'b111_000_000,
    9'b000_111_000,
    9'b000_000_111
  };

  localparam logic [15:0] COL_X0 = 16'd0;
  localparam logic [15:0] COL_X1 = 16'd213;
  localparam logic [15:0] COL_X2 = 16'd426;
  localparam logic [15:0] COL_X3 = 16'd640;
  localparam logic [9:0]  ROW_Y0 = 10'd0;
  localparam logic [9:0]  ROW_Y1 = 10'd160;
  localparam logic [9:0]  ROW_Y2 = 10'd320;
  localparam logic [9:0]  ROW_Y3 = 10'd480;

  localparam logic [3:0] CURSOR_HOME = 4'd4;

  // One move per cycle, wrapping inside the current row/column; up > down > left > right.
  function automatic logic [3:0] cursor_move(input logic [3:0] idx, input logic up,
                                             input logic down, input logic left,
                                             input logic right);
    logic [3:0] col;
    logic [3:0] nxt;
    col = idx % 4'd3;
    nxt = idx;
    if (up)         nxt = (idx >= 4'd3) ? idx - 4'd3 : idx + 4'd6;
    else if (down)  nxt = (idx <  4'd6) ? idx + 4'd3 : idx - 4'd6;
    else if (left)  nxt = (col == 4'd0) ? idx + 4'd2 : idx - 4'd1;
    else if (right) nxt = (col == 4'd2) ? idx - 4'd2 : idx + 4'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/tictactoe_game_fsm_line_checker.sv
// Combinational evaluation of the eight winning lines and board fullness.
module tictactoe_line_checker
  import tictactoe_pkg::*;
(
  input  logic [17:0] board_i,
  output logic        x_win_o,
  output logic        o_win_o,
  output logic [8:0]  win_mask_o,
  output logic        full_o
);

  logic [8:0]           is_x;
  logic [8:0]           is_o;
  logic [NUM_LINES-1:0] line_x;
  logic [NUM_LINES-1:0] line_o;

  genvar gi;
  for (gi = 0; gi < 9; gi++) begin : g_cell
    assign is_x[gi] = (board_i[2*gi +: 2] == MARK_X);
    assign is_o[gi] = (board_i[2*gi +: 2] == MARK_O);
  end

  // A line is won when every cell outside its mask is a don't-care and every cell inside matches.
  for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
    assign line_x[gi] = &(is_x | ~WIN_LINES[gi]);
    assign line_o[gi] = &(is_o | ~WIN_LINES[gi]);
  end

  always_comb begin
    win_mask_o = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_x[i] || line_o[i]) win_mask_o = win_mask_o | WIN_LINES[i];
    end
  end

  assign x_win_o = |line_x;
  assign o_win_o = |line_o;
  assign full_o  = &(is_x | is_o);

endmodule

// File: rtl/tictactoe_game_fsm.sv
// Tic-tac-toe game sequencer: cursor, mark placement, turn timer, win/draw detection.
module tictactoe_game_fsm
  import tictactoe_pkg::*;
#(
  parameter int TURN_TICKS = 250_000_000,
  parameter int TIMER_W    = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  who,
  output logic [8:0]  winner_play,
  output logic [15:0] selected_square_startX,
  output logic [15:0] selected_square_endX,
  output logic [9:0]  selected_square_startY,
  output logic [9:0]  selected_square_endY,
  output logic        timeout
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TICKS - 1);

  state_t             state_q, state_d;
  logic [17:0]        board_q, board_d;
  logic [1:0]         turn_q, turn_d;
  logic [1:0]         who_q, who_d;
  logic [8:0]         win_q, win_d;
  logic [3:0]         cursor_q, cursor_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        sx_q, sx_d, ex_q, ex_d;
  logic [9:0]         sy_q, sy_d, ey_q, ey_d;

  logic       x_win, o_win, full;
  logic [8:0] win_mask;
  logic [1:0] cur_cell;
  logic       sel_valid;
  logic [1:0] other_turn;

  tictactoe_line_checker u_checker (
    .board_i    (board_q),
    .x_win_o    (x_win),
    .o_win_o    (o_win),
    .win_mask_o (win_mask),
    .full_o     (full)
  );

  assign cur_cell   = board_q[{cursor_q, 1'b0} +: 2];
  assign sel_valid  = btn_sel && (state_q == ST_PLAY) && (cur_cell == EMPTY);
  assign other_turn = (turn_q == MARK_X) ? MARK_O : MARK_X;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_PLAY;
      board_q   <= '0;
      turn_q    <= MARK_X;
      who_q     <= RES_NONE;
      win_q     <= '0;
      cursor_q  <= CURSOR_HOME;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      sx_q      <= COL_X1;
      ex_q      <= COL_X2;
      sy_q      <= ROW_Y1;
      ey_q      <= ROW_Y2;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      who_q     <= who_d;
      win_q     <= win_d;
      cursor_q  <= cursor_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      sx_q      <= sx_d;
      ex_q      <= ex_d;
      sy_q      <= sy_d;
      ey_q      <= ey_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PLAY:  if (sel_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = (x_win || o_win || full) ? ST_DONE : ST_PLAY;
      ST_DONE:  if (btn_sel) state_d = ST_PLAY;
      default:  state_d = ST_PLAY;
    endcase
  end

  always_comb begin
    board_d   = board_q;
    turn_d    = turn_q;
    who_d     = who_q;
    win_d     = win_q;
    cursor_d  = cursor_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_PLAY: begin
        // A valid placement in the final tick beats the forfeit.
        if (sel_valid) begin
          board_d[{cursor_q, 1'b0} +: 2] = turn_q;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          turn_d    = other_turn;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (!btn_sel) cursor_d = cursor_move(cursor_q, btn_up, btn_down, btn_left, btn_right);
      end
      ST_CHECK: begin
        if (x_win) begin
          who_d = RES_X;
          win_d = win_mask;
        end else if (o_win) begin
          who_d = RES_O;
          win_d = win_mask;
        end else if (full) begin
          who_d = RES_DRAW;
          win_d = '0;
        end else begin
          turn_d = other_turn;
        end
      end
      ST_DONE: begin
        timer_d = '0;
        if (btn_sel) begin
          board_d  = '0;
          who_d    = RES_NONE;
          win_d    = '0;
          turn_d   = MARK_X;
          cursor_d = CURSOR_HOME;
        end else begin
          cursor_d = cursor_move(cursor_q, btn_up, btn_down, btn_left, btn_right);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (cursor_q % 4'd3)
      4'd0:    begin sx_d = COL_X0; ex_d = COL_X1; end
      4'd1:    begin sx_d = COL_X1; ex_d = COL_X2; end
      default: begin sx_d = COL_X2; ex_d = COL_X3; end
    endcase
    unique case (cursor_q / 4'd3)
      4'd0:    begin sy_d = ROW_Y0; ey_d = ROW_Y1; end
      4'd1:    begin sy_d = ROW_Y1; ey_d = ROW_Y2; end
      default: begin sy_d = ROW_Y2; ey_d = ROW_Y3; end
    endcase
  end

  assign board                  = board_q;
  assign turn                   = turn_q;
  assign who                    = who_q;
  assign winner_play            = win_q;
  assign timeout                = timeout_q;
  assign selected_square_startX = sx_q;
  assign selected_square_endX   = ex_q;
  assign selected_square_startY = sy_q;
  assign selected_square_endY   = ey_q;

endmodule

// File: tb/tb_tictactoe_game_fsm.sv
// Bench for tictactoe_game_fsm: cursor vector table, directed game sequences, random play vs a game model.
module tb_tictactoe_game_fsm;

  localparam int TT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [17:0] board;
  logic [1:0]  turn, who;
  logic [8:0]  winner_play;
  logic [15:0] sx, ex;
  logic [9:0]  sy, ey;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit verbose = 1'b1;

  tictactoe_game_fsm #(.TURN_TICKS(TT), .TIMER_W(5)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .btn_up                 (btn_up),
    .btn_down               (btn_down),
    .btn_left               (btn_left),
    .btn_right              (btn_right),
    .btn_sel                (btn_sel),
    .board                  (board),
    .turn                   (turn),
    .who                    (who),
    .winner_play            (winner_play),
    .selected_square_startX (sx),
    .selected_square_endX   (ex),
    .selected_square_startY (sy),
    .selected_square_endY   (ey),
    .timeout                (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- game model ----------------
  int   m_cells[9];
  int   m_r, m_c, m_turn, m_who, m_timer, m_sq;
  logic [8:0] m_mask;
  bit   m_checking, m_done, m_timeout;
  int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int   xs[4] = '{0, 213, 426, 640};
  int   ys[4] = '{0, 160, 320, 480};

  function automatic void model_new_game();
    for (int i = 0; i < 9; i++) m_cells[i] = 0;
    m_r = 1; m_c = 1; m_turn = 1; m_who = 0; m_mask = '0; m_timer = 0;
    m_checking = 0; m_done = 0;
  endfunction

  function automatic void model_reset();
    model_new_game();
    m_sq = 4; m_timeout = 0;
  endfunction

  function automatic void model_move(input bit u, input bit d, input bit l, input bit r);
    if (u)      m_r = (m_r + 2) % 3;
    else if (d) m_r = (m_r + 1) % 3;
    else if (l) m_c = (m_c + 2) % 3;
    else if (r) m_c = (m_c + 1) % 3;
  endfunction

  function automatic void model_step(input bit u, input bit d, input bit l, input bit r, input bit s);
    int idx;
    bit xw, ow, full;
    logic [8:0] mask;
    idx = m_r * 3 + m_c;
    m_sq = idx;
    m_timeout = 0;
    if (m_checking) begin
      xw = 0; ow = 0; mask = '0; full = 1;
      for (int k = 0; k < 8; k++) begin
        int a;
        a = m_cells[lines[k][0]];
        if (a != 0 && a == m_cells[lines[k][1]] && a == m_cells[lines[k][2]]) begin
          if (a == 1) xw = 1; else ow = 1;
          mask = mask | (9'd1 << lines[k][0]) | (9'd1 << lines[k][1]) | (9'd1 << lines[k][2]);
        end
      end
      for (int i = 0; i < 9; i++) if (m_cells[i] == 0) full = 0;
      if (xw || ow) begin
        m_who = xw ? 1 : 2; m_mask = mask; m_done = 1;
      end else if (full) begin
        m_who = 3; m_mask = '0; m_done = 1;
      end else begin
        m_turn = 3 - m_turn;
      end
      m_checking = 0;
    end else if (m_done) begin
      if (s) model_new_game();
      else   model_move(u, d, l, r);
    end else begin
      if (s && m_cells[idx] == 0) begin
        m_cells[idx] = m_turn; m_timer = 0; m_checking = 1;
      end else if (m_timer == TT - 1) begin
        m_turn = 3 - m_turn; m_timer = 0; m_timeout = 1;
      end else begin
        m_timer++;
      end
      if (!s) model_move(u, d, l, r);
    end
  endfunction

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
    return b;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model board", 32'(board), 32'(model_board()));
    chk("model turn", 32'(turn), m_turn);
    chk("model who", 32'(who), m_who);
    chk("model winner_play", 32'(winner_play), 32'(m_mask));
    chk("model startX", 32'(sx), xs[m_sq % 3]);
    chk("model endX", 32'(ex), xs[m_sq % 3 + 1]);
    chk("model startY", 32'(sy), ys[m_sq / 3]);
    chk("model endY", 32'(ey), ys[m_sq / 3 + 1]);
    chk("model timeout", 32'(timeout), 32'(m_timeout));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " board"}, 32'(board), 0);
    chk({tag, " turn"}, 32'(turn), 1);
    chk({tag, " who"}, 32'(who), 0);
    chk({tag, " winner_play"}, 32'(winner_play), 0);
    chk({tag, " startX"}, 32'(sx), 213);
    chk({tag, " endX"}, 32'(ex), 426);
    chk({tag, " startY"}, 32'(sy), 160);
    chk({tag, " endY"}, 32'(ey), 320);
    chk({tag, " timeout"}, 32'(timeout), 0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit u, input bit d, input bit l, input bit r, input bit s);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
    @(posedge clk);
    model_step(u, d, l, r, s);
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    if (verbose)
      $display("t=%0t btn u%0d d%0d l%0d r%0d s%0d -> board=%05h turn=%0d who=%0d win=%03h sq=%0d/%0d/%0d/%0d to=%0d",
               $time, u, d, l, r, s, board, turn, who, winner_play, sx, ex, sy, ey, timeout);
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic goto_cell(input int t);
    while (m_r != t / 3) cycle(0, 1, 0, 0, 0);
    while (m_c != t % 3) cycle(0, 0, 0, 1, 0);
  endtask

  task automatic place(input int k);
    goto_cell(k - 1);
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic place_check(input int k);
    place(k);
    cycle(0, 0, 0, 0, 0);
  endtask

  // ---------------- cursor vector table ----------------
  typedef struct {
    bit u, d, l, r;
    int sx, ex, sy, ey;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0,0,0,1, 426,640,160,320};
    vecs[1]  = '{0,0,0,1,   0,213,160,320};
    vecs[2]  = '{0,1,0,0,   0,213,320,480};
    vecs[3]  = '{1,0,0,0,   0,213,160,320};
    vecs[4]  = '{1,0,0,0,   0,213,  0,160};
    vecs[5]  = '{1,0,0,0,   0,213,320,480};
    vecs[6]  = '{0,0,1,0, 426,640,320,480};
    vecs[7]  = '{0,1,0,0, 426,640,  0,160};
    vecs[8]  = '{0,0,1,0, 213,426,  0,160};
    vecs[9]  = '{1,1,1,0, 213,426,320,480};
    vecs[10] = '{0,0,1,1,   0,213,320,480};
    vecs[11] = '{0,0,0,1, 213,426,320,480};

    rst = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, 0);
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("vec%0d startX", i), 32'(sx), vecs[i].sx);
      chk($sformatf("vec%0d endX", i), 32'(ex), vecs[i].ex);
      chk($sformatf("vec%0d startY", i), 32'(sy), vecs[i].sy);
      chk($sformatf("vec%0d endY", i), 32'(ey), vecs[i].ey);
    end

    // X wins on the top row
    do_reset();
    place_check(1); place_check(4); place_check(2); place_check(5);
    place(3);
    chk("xwin board", 32'(board), 32'h00295);
    chk("xwin who at sel+1", 32'(who), 0);
    cycle(0, 0, 0, 0, 0);
    chk("xwin who", 32'(who), 1);
    chk("xwin winner_play", 32'(winner_play), 32'h007);
    cycle(0, 0, 0, 1, 0);
    chk("done keeps board", 32'(board), 32'h00295);
    chk("done keeps who", 32'(who), 1);

    // Occupied cell select is ignored and does not restart the timer
    do_reset();
    place_check(5);
    chk("occ turn after X", 32'(turn), 2);
    for (int i = 1; i <= TT; i++) begin
      cycle(0, 0, 0, 0, i == 5);
      if (i == 5) begin
        chk("occ board", 32'(board), 32'h00100);
        chk("occ turn", 32'(turn), 2);
      end
      chk($sformatf("occ timeout i=%0d", i), 32'(timeout), 32'(i == TT));
    end
    chk("occ forfeit turn", 32'(turn), 1);

    // Idle timeout from reset
    do_reset();
    for (int i = 1; i <= TT + 1; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("idle timeout i=%0d", i), 32'(timeout), 32'(i == TT));
    end
    chk("idle forfeit turn", 32'(turn), 2);

    // Select in the final tick beats the forfeit
    do_reset();
    for (int i = 1; i < TT; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("lasttick timeout", 32'(timeout), 0);
    chk("lasttick board", 32'(board), 32'h00100);
    cycle(0, 0, 0, 0, 0);
    chk("lasttick turn", 32'(turn), 2);
    chk("lasttick timeout2", 32'(timeout), 0);

    // Draw, then restart
    do_reset();
    place_check(1); place_check(3); place_check(2); place_check(4);
    place_check(6); place_check(5); place_check(7); place_check(8);
    place(9);
    chk("draw board", 32'(board), 32'h196A5);
    cycle(0, 0, 0, 0, 0);
    chk("draw who", 32'(who), 3);
    chk("draw winner_play", 32'(winner_play), 0);
    cycle(0, 0, 0, 0, 1);
    chk("restart board", 32'(board), 0);
    chk("restart who", 32'(who), 0);
    chk("restart turn", 32'(turn), 1);
    cycle(0, 0, 0, 0, 0);
    chk("restart startX", 32'(sx), 213);
    chk("restart startY", 32'(sy), 160);

    // Select with up: mark on old cursor, cursor stays; then async reset during CHECK
    do_reset();
    cycle(1, 0, 0, 0, 1);
    chk("selup board", 32'(board), 32'h00100);
    cycle(0, 0, 0, 0, 0);
    chk("selup startY", 32'(sy), 160);
    chk("selup startX", 32'(sx), 213);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    chk("pre-reset board", 32'(board), 32'h00900);
    rst = 1'b0;
    #1;
    check_reset_values("async reset");
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;

    // Random play against the model
    verbose = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      bit u, d, l, r, s;
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) == 0);
      cycle(u, d, l, r, s);
      if (s)
        $display("rand %0d sel -> board=%05h turn=%0d who=%0d win=%03h", n, board, turn, who, winner_play);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
